reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//  - General-purpose register file for the CPU datapath: 2^ADDR_WIDTH words of DATA_WIDTH bits.
//  - Two asynchronous read ports and one synchronous write port.
//  - Register 0 is hardwired to zero.
//  - Sits between decode (operand fetch) and writeback in the single-cycle/multi-cycle core.
// PARAMETERS
//  DATA_WIDTH  32  width of each register and of wdata/rdata1/rdata2
//  ADDR_WIDTH  5   address width; depth = 2**ADDR_WIDTH (32 registers)
// PORTS
//  - Interface: one clock; reset is asynchronous and active-high.
//  clk     in   1           rising-edge clock for all writes
//  rst     in   1           asynchronous, active-high reset; clears every register
//  waddr   in   ADDR_WIDTH  write address
//  wen     in   1           write enable, sampled on rising clk edge
//  wdata   in   DATA_WIDTH  write data
//  raddr1  in   ADDR_WIDTH  read address, port 1
//  raddr2  in   ADDR_WIDTH  read address, port 2
//  rdata1  out  DATA_WIDTH  read data, port 1 (combinational)
//  rdata2  out  DATA_WIDTH  read data, port 2 (combinational)
// BEHAVIOUR
//  - Reset:
//    - rst=1 clears all registers to 0 immediately, independent of clk.
//    - While rst is held, writes are ignored and rdata1/rdata2 read 0.
//    - Deassertion mid-cycle has no effect until the next rising edge.
//  - Write:
//    - On posedge clk with rst=0 and wen=1 and waddr!=0: reg[waddr] <= wdata.
//    - Latency is 1 cycle; the new value is visible on the read ports after that edge.
//  - Register 0:
//    - Writes to waddr=0 are discarded.
//    - Reads of address 0 always return 0 on both ports.
//  - Read:
//    - rdataN = (raddrN==0) ? 0 : reg[raddrN], purely combinational, zero latency.
//    - The read path has no clock or enable.
//  - Read/write same address in the same cycle:
//    - No bypass. rdataN shows the old value until the clock edge, then the new value.
//  - Both read ports may address the same register simultaneously; both return the same data.
//  - wen=0: no register changes regardless of waddr/wdata.
//  - X/unknown inputs: no special handling required.
// STRUCTURE
//  - Shared package: DATA_WIDTH=32, ADDR_WIDTH=5 and the derived depth constant.
//    - The core and its testbenches take their widths from these.
//  - Single module with a DATA_WIDTH x 2**ADDR_WIDTH register array:
//    - a write always-block sensitive to posedge clk / posedge rst;
//    - two continuous-assign read muxes.
//  - No sub-module.
// TESTING
//  - Reset: hold rst=1, clock several edges with wen=1
//    -> rdata1=rdata2=0 for every raddr 0..31; no register written.
//  - Write/read: rst=0; write 32'h0000_07CF to r5 (wen=1) at one edge
//    -> after the edge, raddr1=5 gives 32'h0000_07CF; raddr2=5 gives the same.
//  - Register 0: wen=1, waddr=0, wdata=32'hFFFF_FFFF
//    -> rdata1 with raddr1=0 stays 32'h0.
//  - wen gating: r7=32'd100; then wen=0, waddr=7, wdata=32'd1999 at an edge
//    -> r7 still reads 32'd100.
//  - Same-cycle read/write: raddr1=waddr=9, r9=32'd3, wdata=32'd42, wen=1
//    -> rdata1=3 before the edge, 42 after it.
//  - Async reset mid-run: fill r1..r31 with random values < 2000 (random wen);
//    assert rst between clock edges
//    -> all reads return 0 at once, without waiting for a clock edge.
//    Checker compares every read against a reference model during the sweep.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared widths and types for the CPU general-purpose register file.
// The core and its testbench both take their sizing from here.
package reg_file_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/reg_file_if.sv
// Operand-fetch / writeback bus of the register file.
// The master (the datapath) drives addresses and write data; the slave returns read data.
interface reg_file_if;
  import reg_file_pkg::*;

  addr_t waddr;
  logic  wen;
  data_t wdata;
  addr_t raddr1;
  addr_t raddr2;
  data_t rdata1;
  data_t rdata2;

  modport master (
    output waddr, wen, wdata, raddr1, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  waddr, wen, wdata, raddr1, raddr2,
    output rdata1, rdata2
  );

endinterface

// File: rtl/reg_file.sv
// General-purpose register file: one synchronous write port and two combinational read ports.
// Register 0 is hardwired to zero.
module reg_file
  import reg_file_pkg::*;
(
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    if (bus.wen && (bus.waddr != '0)) begin
      regs_d[bus.waddr] = bus.wdata;
    end
    // Keeps entry 0 constant so the read muxes never see a stale value there.
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // No write-to-read bypass: a same-cycle write only shows after the edge.
  assign bus.rdata1 = (bus.raddr1 == '0) ? '0 : regs_q[bus.raddr1];
  assign bus.rdata2 = (bus.raddr2 == '0) ? '0 : regs_q[bus.raddr2];

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard testbench for reg_file: stimulus pushes expected read data,
// a separate monitor pops and compares when each read sample is presented.
module tb_reg_file;
  import reg_file_pkg::*;

  typedef struct {
    string name;
    data_t exp1;
    data_t exp2;
  } exp_t;

  logic clk;
  logic rst;

  reg_file_if bus_if ();

  reg_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  exp_t  sb_q[$];
  event  sample_ev;
  int    errors;
  int    checks;
  data_t ref_regs [DEPTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive every master-side bus field at once.
  task automatic applyStimulus(input logic wen, input addr_t waddr, input data_t wdata,
                               input addr_t raddr1, input addr_t raddr2);
    bus_if.wen    = wen;
    bus_if.waddr  = waddr;
    bus_if.wdata  = wdata;
    bus_if.raddr1 = raddr1;
    bus_if.raddr2 = raddr2;
  endtask

  // Queue the expected read data, then present the sample to the monitor.
  task automatic checkOutput(input string name, input data_t exp1, input data_t exp2);
    exp_t e;
    e.name = name;
    e.exp1 = exp1;
    e.exp2 = exp2;
    sb_q.push_back(e);
    #1;
    -> sample_ev;
    #1;
  endtask

  // One write at the next rising edge; wen drops 1ns after that edge.
  task automatic doWrite(input addr_t waddr, input data_t wdata);
    @(negedge clk);
    bus_if.wen   = 1'b1;
    bus_if.waddr = waddr;
    bus_if.wdata = wdata;
    @(posedge clk);
    if (waddr != '0) ref_regs[waddr] = wdata;
    #1;
    bus_if.wen = 1'b0;
  endtask

  // Monitor: pops one expectation per presented sample and compares both ports.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (sb_q.size() == 0) begin
        errors++;
        checks++;
        $display("[TB] FAIL scoreboard_empty: sample presented, got no expectation, required one queued");
      end else begin
        e = sb_q.pop_front();
        checks++;
        if (bus_if.rdata1 !== e.exp1) begin
          errors++;
          $display("[TB] FAIL %s rdata1: got %h required %h", e.name, bus_if.rdata1, e.exp1);
        end
        checks++;
        if (bus_if.rdata2 !== e.exp2) begin
          errors++;
          $display("[TB] FAIL %s rdata2: got %h required %h", e.name, bus_if.rdata2, e.exp2);
        end
      end
    end
  end

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time expired before the stimulus completed");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    addr_t a1;
    addr_t a2;
    errors = 0;
    checks = 0;
    for (int i = 0; i < DEPTH; i++) ref_regs[i] = '0;

    // Reset held with writes attempted at several edges.
    rst = 1'b1;
    applyStimulus(1'b1, addr_t'(1), 32'hDEAD_BEEF, '0, '0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus_if.waddr = addr_t'(i * 3);
    end
    for (int i = 0; i < DEPTH; i++) begin
      a1 = addr_t'(i);
      a2 = addr_t'(DEPTH - 1 - i);
      applyStimulus(1'b1, a1, 32'h1234_5678, a1, a2);
      checkOutput("reset_hold", 32'h0, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, '0, '0, addr_t'(3), addr_t'(6));
    @(negedge clk);
    checkOutput("post_reset_empty", 32'h0, 32'h0);

    // Basic write then read on both ports.
    doWrite(addr_t'(5), 32'h0000_07CF);
    applyStimulus(1'b0, '0, '0, addr_t'(5), addr_t'(5));
    checkOutput("write_r5", 32'h0000_07CF, 32'h0000_07CF);

    // Register 0 discards writes.
    doWrite(addr_t'(0), 32'hFFFF_FFFF);
    applyStimulus(1'b0, '0, '0, addr_t'(0), addr_t'(0));
    checkOutput("r0_hardwired", 32'h0, 32'h0);
    applyStimulus(1'b0, '0, '0, addr_t'(0), addr_t'(5));
    checkOutput("r0_and_r5", 32'h0, 32'h0000_07CF);

    // wen=0 leaves r7 untouched.
    doWrite(addr_t'(7), 32'd100);
    @(negedge clk);
    applyStimulus(1'b0, addr_t'(7), 32'd1999, addr_t'(7), addr_t'(7));
    @(posedge clk);
    #1;
    checkOutput("wen_gating", 32'd100, 32'd100);

    // Same-cycle read/write: old value before the edge, new value after.
    doWrite(addr_t'(9), 32'd3);
    @(negedge clk);
    applyStimulus(1'b1, addr_t'(9), 32'd42, addr_t'(9), addr_t'(5));
    checkOutput("same_cycle_before", 32'd3, 32'h0000_07CF);
    @(posedge clk);
    ref_regs[9] = 32'd42;
    #1;
    bus_if.wen = 1'b0;
    checkOutput("same_cycle_after", 32'd42, 32'h0000_07CF);

    // Random fill of r1..r31 with random write enables.
    for (int i = 1; i < DEPTH; i++) begin
      @(negedge clk);
      bus_if.wen   = 1'($urandom_range(0, 1));
      bus_if.waddr = addr_t'(i);
      bus_if.wdata = data_t'($urandom_range(0, 1999));
      @(posedge clk);
      if (bus_if.wen) ref_regs[i] = bus_if.wdata;
      #1;
      bus_if.wen = 1'b0;
    end
    // Guarantee at least one non-zero register to observe the reset clearing.
    doWrite(addr_t'(31), 32'd1234);
    for (int i = 0; i < DEPTH; i++) begin
      a1 = addr_t'(i);
      a2 = addr_t'(DEPTH - 1 - i);
      applyStimulus(1'b0, '0, '0, a1, a2);
      checkOutput("fill_sweep", ref_regs[a1], ref_regs[a2]);
    end

    // Asynchronous reset asserted between edges must clear reads at once.
    applyStimulus(1'b0, '0, '0, addr_t'(31), addr_t'(9));
    @(negedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_regs[i] = '0;
    checkOutput("async_reset_now", 32'h0, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      a1 = addr_t'(i);
      a2 = addr_t'(DEPTH - 1 - i);
      applyStimulus(1'b0, '0, '0, a1, a2);
      checkOutput("async_reset_sweep", ref_regs[a1], ref_regs[a2]);
    end

    #5;
    if (sb_q.size() != 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
